// File: rtl/phy_rx_deserializer_pkg.sv
// rtl/phy_rx_deserializer_pkg.sv - shared link constants and receive FSM encoding
package phy_rx_deserializer_pkg;

  localparam logic [7:0] COM_BYTE  = 8'hBC;
  localparam int         COM_COUNT = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    SYNCED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/phy_rx_aligner.sv
// rtl/phy_rx_aligner.sv - bit-granular COM search, byte-boundary confirm and sync tracking
module phy_rx_aligner
  import phy_rx_deserializer_pkg::*;
#(
  parameter logic [7:0] COM_BYTE  = phy_rx_deserializer_pkg::COM_BYTE,
  parameter int         COM_COUNT = phy_rx_deserializer_pkg::COM_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_serial,
  input  logic       resync,
  output logic [7:0] rx_byte,
  output logic       is_com,
  output logic       byte_done,
  output logic       synced
);

  localparam int            CW       = $clog2(COM_COUNT + 1);
  localparam logic [CW-1:0] COM_LAST = CW'(COM_COUNT - 1);

  rx_state_t     state;
  // Older seven bits of the window; the live data_serial bit completes the byte.
  logic [6:0]    sr;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] com_cnt;

  assign rx_byte   = {sr, data_serial};
  assign is_com    = (rx_byte == COM_BYTE);
  assign byte_done = (state == SYNCED) && (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      sr      <= '0;
      bit_cnt <= '0;
      com_cnt <= '0;
      synced  <= 1'b0;
    end else begin
      sr <= rx_byte[6:0];
      if (resync) begin
        state   <= SEARCH;
        bit_cnt <= '0;
        com_cnt <= '0;
        synced  <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            bit_cnt <= '0;
            if (is_com) begin
              com_cnt <= CW'(1);
              if (COM_COUNT <= 1) begin
                state  <= SYNCED;
                synced <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!is_com) begin
                state   <= SEARCH;
                com_cnt <= '0;
              end else begin
                com_cnt <= com_cnt + CW'(1);
                if (com_cnt == COM_LAST) begin
                  state  <= SYNCED;
                  synced <= 1'b1;
                end
              end
            end
          end
          SYNCED: begin
            bit_cnt <= bit_cnt + 3'd1;
          end
          default: begin
            state   <= SEARCH;
            bit_cnt <= '0;
            com_cnt <= '0;
            synced  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/phy_rx_deserializer.sv
// rtl/phy_rx_deserializer.sv - serial receive path: alignment plus 32-bit word assembly
module phy_rx_deserializer
  import phy_rx_deserializer_pkg::*;
#(
  parameter logic [7:0] COM_BYTE  = phy_rx_deserializer_pkg::COM_BYTE,
  parameter int         COM_COUNT = phy_rx_deserializer_pkg::COM_COUNT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_serial,
  input  logic        resync,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        err_partial
);

  logic [7:0]  rx_byte;
  logic        is_com;
  logic        byte_done;
  logic [1:0]  byte_idx;
  // Lanes 3..1 of the word in flight; lane 0 comes straight from rx_byte.
  logic [23:0] word_buf;

  phy_rx_aligner #(
    .COM_BYTE  (COM_BYTE),
    .COM_COUNT (COM_COUNT)
  ) u_aligner (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_serial (data_serial),
    .resync      (resync),
    .rx_byte     (rx_byte),
    .is_com      (is_com),
    .byte_done   (byte_done),
    .synced      (active)
  );

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      err_partial <= 1'b0;
      byte_idx    <= '0;
      word_buf    <= '0;
    end else begin
      err_partial <= 1'b0;
      if (resync) begin
        byte_idx  <= '0;
        valid_out <= 1'b0;
      end else if (byte_done) begin
        if (is_com) begin
          err_partial <= (byte_idx != 2'd0);
          byte_idx    <= '0;
          valid_out   <= 1'b0;
        end else begin
          case (byte_idx)
            2'd0: word_buf[23:16] <= rx_byte;
            2'd1: word_buf[15:8]  <= rx_byte;
            2'd2: word_buf[7:0]   <= rx_byte;
            default: begin
              data_out  <= {word_buf, rx_byte};
              valid_out <= 1'b1;
            end
          endcase
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/phy_rx_deserializer.md
PHY_RX_DESERIALIZER -- requirements
Module: phy_rx_deserializer

Interface
REQ-001 Parameter COM_BYTE, default 8'hBC, is the comma/idle symbol sent by the transmitter between words.
REQ-002 Parameter COM_COUNT, default 4, is the number of consecutive byte-aligned COM symbols required to declare sync.
REQ-003 The block SHALL use one clock, clk_32f, and an asynchronous active-high reset, reset.
REQ-004 clk_32f  input  1  serial bit clock; one bit sampled per rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 data_serial  input  1  serial bit stream, MSB of each byte first.
REQ-007 resync  input  1  synchronous one-cycle request to drop sync and return to SEARCH.
REQ-008 data_out  output  32  last recovered word; first received byte in [31:24].
REQ-009 valid_out  output  1  high while data_out holds a word from the current data burst.
REQ-010 active  output  1  high while the block is byte-aligned and synced.
REQ-011 err_partial  output  1  one-cycle pulse when a COM arrives with 1-3 data bytes of a word pending.

Function
REQ-012 An 8-bit shift register SHALL shift data_serial in at the LSB every cycle; the candidate byte is {sr[6:0], data_serial}.
REQ-013 A 3-bit bit counter SHALL mark byte boundaries: a byte completes on the edge where bit_cnt==7, and bit_cnt wraps 7->0.
REQ-014 FSM states: SEARCH, CONFIRM, SYNCED.
REQ-015 SEARCH: the candidate byte is compared every cycle (bit-granular); on a match, go to CONFIRM with com_cnt=1 and bit_cnt=0, with the next bit starting a new byte.
REQ-016 CONFIRM: at each byte completion, COM increments com_cnt, and on reaching COM_COUNT the block goes to SYNCED; a non-COM byte returns to SEARCH with com_cnt=0.
REQ-017 SYNCED: active=1; a COM byte clears byte index to 0 and drives valid_out=0; a non-COM byte is written to lane (3-byte_idx) and byte_idx increments.
REQ-018 On completion of the 4th data byte, data_out SHALL load the assembled word and valid_out SHALL go 1 on that same edge; byte_idx wraps 3->0.
REQ-019 Latency: data_out/valid_out update on the rising edge that samples the last bit of the word (0 cycles after the final bit).
REQ-020 data_out SHALL hold between words; it changes only when a word completes.
REQ-021 COM with byte_idx in 1..3 SHALL discard the partial word, leave data_out unchanged, and pulse err_partial for one cycle.
REQ-022 resync in any state SHALL force SEARCH with active=0, valid_out=0, com_cnt=0, byte_idx=0, and data_out held; resync wins over a simultaneous byte completion.
REQ-023 Back-to-back words with no COM between them SHALL each assert the update with valid_out held high continuously.

Reset
REQ-024 While reset=1: state=SEARCH, sr=0, bit_cnt=0, com_cnt=0, byte_idx=0, data_out=32'h0, valid_out=0, active=0, err_partial=0.
REQ-025 Reset asserted mid-word SHALL discard all partial state immediately, without waiting for a clock edge.

Structure
REQ-026 A shared package SHALL hold COM_BYTE, COM_COUNT, and the FSM state encoding, shared with the transmit serializer.
REQ-027 One sub-module, phy_rx_aligner (shift register, bit counter, and SEARCH/CONFIRM logic), is natural; word assembly stays in the top level.

Verification
REQ-028 Send 4x 8'hBC after reset -> active rises on the edge sampling the last bit of the 4th COM.
REQ-029 After sync, send bytes FF,FF,FF,FF then EE,EE,EE,EE -> data_out=32'hFFFF_FFFF then 32'hEEEE_EEEE, with valid_out high throughout both words.
REQ-030 Send 3 random bits, then 4x BC, then DD,DD,DD,DD -> alignment recovers, and data_out=32'hDDDD_DDDD.
REQ-031 While synced, send CC,CC, then BC -> err_partial pulses once, valid_out=0, and data_out keeps its previous value.
REQ-032 Send BC,BC,12,BC... -> the FSM returns to SEARCH after byte 12, and active stays 0 until 4 fresh consecutive COMs.
REQ-033 Assert resync (and separately reset) mid-word -> active=0 and valid_out=0; with reset, data_out=0.
